// File: rtl/gray_pkg.sv
// Shared types and helpers for the 3-bit Gray counter monitor.
package gray_pkg;

    localparam int unsigned GRAY_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Classifies one sample against the previously accepted sample.
module gray_step_check
    import gray_pkg::*;
(
    input  logic [GRAY_W-1:0] prev_gray,
    input  logic [GRAY_W-1:0] gray_in,
    input  logic              prev_ovf,
    input  logic              ovf_in,
    output logic              is_hold,
    output logic              is_step,
    output logic              is_wrap,
    output logic              is_illegal
);

    localparam logic [GRAY_W-1:0] ONE = GRAY_W'(1);

    logic [GRAY_W-1:0] old_bin;
    logic [GRAY_W-1:0] new_bin;
    logic              advance;
    logic              old_is_max;
    logic              ovf_rise;
    logic              ovf_fall;

    assign old_bin    = gray2bin(prev_gray);
    assign new_bin    = gray2bin(gray_in);
    assign advance    = (new_bin == (old_bin + ONE));
    assign old_is_max = &old_bin;
    assign ovf_rise   = ~prev_ovf & ovf_in;
    assign ovf_fall   = prev_ovf & ~ovf_in;

    // Overflow may only rise together with a 7->0 advance and may never fall.
    always_comb begin
        is_hold    = (gray_in == prev_gray) && (ovf_in == prev_ovf);
        is_step    = advance && !ovf_fall && !(ovf_rise && !old_is_max);
        is_wrap    = is_step && old_is_max;
        is_illegal = !is_hold && !is_step;
    end

endmodule

// File: rtl/gray_monitor.sv
// Checker/decoder for the upstream 3-bit Gray counter: decodes, counts laps,
// and latches a sticky fault on any illegal transition.
module gray_monitor
    import gray_pkg::*;
#(
    parameter int unsigned LAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [GRAY_W-1:0] GrayIn,
    input  logic              OverflowIn,
    output logic [GRAY_W-1:0] Binary,
    output logic              Step,
    output logic              Wrap,
    output logic [LAP_W-1:0]  Laps,
    output logic              Error,
    output logic [1:0]        State
);

    state_t            state_q, state_d;
    logic [GRAY_W-1:0] binary_q, binary_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic [LAP_W-1:0]  laps_q, laps_d;
    logic              error_q, error_d;
    logic [GRAY_W-1:0] prev_gray_q, prev_gray_d;
    logic              prev_ovf_q, prev_ovf_d;

    logic is_hold;
    logic is_step;
    logic is_wrap;
    logic is_illegal;

    gray_step_check u_step_check (
        .prev_gray  (prev_gray_q),
        .gray_in    (GrayIn),
        .prev_ovf   (prev_ovf_q),
        .ovf_in     (OverflowIn),
        .is_hold    (is_hold),
        .is_step    (is_step),
        .is_wrap    (is_wrap),
        .is_illegal (is_illegal)
    );

    // Next-state: sync on first sample, then accept legal steps or trap in FAULT.
    always_comb begin
        state_d     = state_q;
        binary_d    = binary_q;
        step_d      = 1'b0;
        wrap_d      = 1'b0;
        laps_d      = laps_q;
        error_d     = error_q;
        prev_gray_d = prev_gray_q;
        prev_ovf_d  = prev_ovf_q;
        unique case (state_q)
            IDLE: begin
                prev_gray_d = GrayIn;
                prev_ovf_d  = OverflowIn;
                binary_d    = gray2bin(GrayIn);
                state_d     = TRACK;
            end
            TRACK: begin
                if (is_illegal) begin
                    state_d = FAULT;
                    error_d = 1'b1;
                end else if (is_step) begin
                    step_d      = 1'b1;
                    wrap_d      = is_wrap;
                    binary_d    = gray2bin(GrayIn);
                    prev_gray_d = GrayIn;
                    prev_ovf_d  = OverflowIn;
                    if (is_wrap && !(&laps_q)) begin
                        laps_d = laps_q + LAP_W'(1);
                    end
                end
            end
            FAULT: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = FAULT;
                error_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            binary_q    <= '0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            laps_q      <= '0;
            error_q     <= 1'b0;
            prev_gray_q <= '0;
            prev_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            binary_q    <= binary_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            laps_q      <= laps_d;
            error_q     <= error_d;
            prev_gray_q <= prev_gray_d;
            prev_ovf_q  <= prev_ovf_d;
        end
    end

    assign Binary = binary_q;
    assign Step   = step_q;
    assign Wrap   = wrap_q;
    assign Laps   = laps_q;
    assign Error  = error_q;
    assign State  = state_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor: two instances (LAP_W=8 and LAP_W=2) share the stimulus,
// a behavioural model is compared every cycle, and literal checks pin the model.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] GrayIn = 3'd0;
    logic       OverflowIn = 1'b0;

    logic [2:0] bin8, bin2;
    logic       step8, step2, wrap8, wrap2, err8, err2;
    logic [7:0] laps8;
    logic [1:0] laps2;
    logic [1:0] st8, st2;

    gray_monitor #(.LAP_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
        .Binary(bin8), .Step(step8), .Wrap(wrap8), .Laps(laps8), .Error(err8), .State(st8)
    );

    gray_monitor #(.LAP_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .OverflowIn(OverflowIn),
        .Binary(bin2), .Step(step2), .Wrap(wrap2), .Laps(laps2), .Error(err2), .State(st2)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference decode by search: the binary b whose Gray code b^(b>>1) equals g.
    function automatic int dec(int g);
        for (int b = 0; b < 8; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return 0;
    endfunction

    // Model: 0 = waiting for first sample, 1 = tracking, 2 = faulted.
    int m_st = 0, m_bin = 0, m_step = 0, m_wrap = 0, m_laps = 0, m_err = 0;
    int m_pg = 0, m_pb = 0, m_po = 0;

    always @(posedge Clk) begin
        int nb, g, o;
        g = int'(GrayIn);
        o = int'(OverflowIn);
        m_step = 0;
        m_wrap = 0;
        if (Reset) begin
            m_st = 0; m_bin = 0; m_laps = 0; m_err = 0; m_pg = 0; m_pb = 0; m_po = 0;
        end else if (m_st == 0) begin
            m_pg = g; m_pb = dec(g); m_po = o; m_bin = m_pb; m_st = 1;
        end else if (m_st == 1) begin
            nb = dec(g);
            if (g == m_pg && o == m_po) begin
                // hold
            end else if (nb == (m_pb + 1) % 8 && !(m_po == 1 && o == 0)
                         && !(m_po == 0 && o == 1 && m_pb != 7)) begin
                m_step = 1;
                if (m_pb == 7) begin
                    m_wrap = 1;
                    m_laps++;
                end
                m_bin = nb; m_pb = nb; m_pg = g; m_po = o;
            end else begin
                m_st = 2;
                m_err = 1;
            end
        end
        #1;
        check("state8", st8, m_st);     check("state2", st2, m_st);
        check("binary8", bin8, m_bin);  check("binary2", bin2, m_bin);
        check("step8", step8, m_step);  check("step2", step2, m_step);
        check("wrap8", wrap8, m_wrap);  check("wrap2", wrap2, m_wrap);
        check("error8", err8, m_err);   check("error2", err2, m_err);
        check("laps8", laps8, (m_laps > 255) ? 255 : m_laps);
        check("laps2", laps2, (m_laps > 3) ? 3 : m_laps);
    end

    logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    int steps = 0;
    int wraps2 = 0;

    task automatic cyc(input logic [2:0] g, input logic o, input logic r);
        @(negedge Clk);
        GrayIn = g;
        OverflowIn = o;
        Reset = r;
        @(posedge Clk);
        #2;
        steps += int'(step8);
        wraps2 += int'(wrap2);
    endtask

    // From binary 0 in TRACK: advance 1..7 then 0; o_end applies to the final 0.
    task automatic run_lap(input logic o_mid, input logic o_end);
        for (int i = 1; i < 8; i++) cyc(seq[i], o_mid, 1'b0);
        cyc(seq[0], o_end, 1'b0);
    endtask

    initial begin
        int exp_bin [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        int exp_l2 [4] = '{2, 3, 3, 3};

        // Reset state
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b1);
        check("rst_state", st8, 0);
        check("rst_error", err8, 0);
        check("rst_laps", laps8, 0);

        // Free-running count, overflow rises on the wrap
        cyc(seq[0], 1'b0, 1'b0);
        check("t1_first_state", st8, 1);
        check("t1_first_step", step8, 0);
        check("t1_bin0", bin8, exp_bin[0]);
        steps = 0;
        for (int i = 1; i < 9; i++) begin
            cyc(seq[i % 8], (i == 8) ? 1'b1 : 1'b0, 1'b0);
            check("t1_bin", bin8, exp_bin[i]);
        end
        check("t1_steps", steps, 8);
        check("t1_wrap", wrap8, 1);
        check("t1_laps", laps8, 1);
        check("t1_error", err8, 0);

        // Hold at 011 for 5 cycles
        cyc(3'b001, 1'b1, 1'b0);
        cyc(3'b011, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b011, 1'b1, 1'b0);
            check("hold_step", step8, 0);
            check("hold_bin", bin8, 2);
            check("hold_err", err8, 0);
        end

        // Saturation: finish lap 2, then laps 3..5 with overflow staying high
        cyc(3'b010, 1'b1, 1'b0);
        cyc(3'b110, 1'b1, 1'b0);
        cyc(3'b111, 1'b1, 1'b0);
        cyc(3'b101, 1'b1, 1'b0);
        cyc(3'b100, 1'b1, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        check("sat_laps2_l2", laps2, exp_l2[0]);
        for (int k = 1; k < 4; k++) begin
            run_lap(1'b1, 1'b1);
            check("sat_laps2", laps2, exp_l2[k]);
        end
        check("sat_wraps", wraps2, 5);
        check("sat_laps8", laps8, 5);
        check("sat_error", err2, 0);

        // Illegal two-bit change 001 -> 010
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b010, 1'b0, 1'b0);
        check("ill_error", err8, 1);
        check("ill_state", st8, 2);
        check("ill_bin", bin8, 1);
        cyc(3'b011, 1'b0, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        check("ill_sticky", err8, 1);
        check("ill_frozen", bin8, 1);
        cyc(3'b000, 1'b0, 1'b1);
        check("ill_rst_state", st8, 0);
        check("ill_rst_error", err8, 0);

        // Overflow rise without wrap (011 -> 010)
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b011, 1'b0, 1'b0);
        cyc(3'b010, 1'b1, 1'b0);
        check("ovf_rise_err", err8, 1);
        cyc(3'b000, 1'b0, 1'b1);

        // Overflow fall after a wrap
        cyc(3'b000, 1'b0, 1'b0);
        run_lap(1'b0, 1'b1);
        check("ovf_wrap_ok", err8, 0);
        cyc(3'b001, 1'b0, 1'b0);
        check("ovf_fall_err", err8, 1);
        cyc(3'b000, 1'b0, 1'b1);

        // Backward step and one-bit skip (001 -> 101)
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b0);
        check("back_err", err8, 1);
        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b101, 1'b0, 1'b0);
        check("skip_err", err8, 1);
        cyc(3'b000, 1'b0, 1'b1);

        // Reset mid-count at 110, then resync on 000, 001
        cyc(3'b000, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b011, 1'b0, 1'b0);
        cyc(3'b010, 1'b0, 1'b0);
        cyc(3'b110, 1'b0, 1'b0);
        cyc(3'b110, 1'b0, 1'b1);
        check("mid_rst_state", st8, 0);
        cyc(3'b000, 1'b0, 1'b0);
        check("mid_track", st8, 1);
        cyc(3'b001, 1'b0, 1'b0);
        check("mid_step", step8, 1);
        check("mid_error", err8, 0);

        cyc(3'b001, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
